srio_ireq_gen: RTL and testbench

- Initiator-request packetizer that sits directly upstream of the SRIO channel's ireq AXI4-Stream slave (HELLO format, 64-bit).
- Converts a user command (type, address, byte length) plus a user data stream into one HELLO packet: one header beat followed by 0..32 data beats.
- Runs in the SRIO log clock domain.
- Owns the transaction-ID counter, length legality checks and tlast generation.

---
 rtl/srio_ireq_gen_if.sv | 16 +
 rtl/srio_ireq_gen.sv | 197 +++++++++++++++++++
 tb/tb_srio_ireq_gen.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/srio_ireq_gen_if.sv
// srio_ireq_gen_if
//   AXI4-Stream (HELLO, 64-bit) link between srio_ireq_gen and the SRIO
//   channel ireq slave.
//   master modport: packetizer side (drives tvalid/tlast/tdata/tkeep/tuser).
//   slave modport : channel side (drives tready).
interface srio_ireq_gen_if;
  logic        tvalid;
  logic        tready;
  logic        tlast;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic [31:0] tuser;

  modport master (output tvalid, tlast, tdata, tkeep, tuser, input tready);
  modport slave  (input tvalid, tlast, tdata, tkeep, tuser, output tready);
endinterface

// File: rtl/srio_ireq_gen.sv
// srio_ireq_gen
//   Initiator-request packetizer for the SRIO ireq stream (HELLO format).
//   Turns one user command (type/addr/len) plus the user data stream into a
//   header beat followed by 0..32 data beats. Owns the TID counter, length
//   legality checks and tlast generation. Runs in the SRIO log clock domain.
//
// Ports
//   i_clk, i_rst          clock, synchronous active-low reset
//   i_port_initialized    link up; gates command acceptance
//   i_req_valid/o_req_ready, i_req_type, i_req_addr, i_req_len
//                         command handshake (type 0=NWRITE 1=NWRITE_R
//                         2=SWRITE 3=NREAD, len in bytes 1..256)
//   o_req_err             one-cycle pulse on a rejected command
//   s_data_tvalid/s_data_tready/s_data_tdata
//                         user write-data stream
//   m_axis_ireq           ireq stream (srio_ireq_gen_if.master)
//   o_busy                high whenever not idle
//   o_timeout             data-stall pulse (SRIO_IREQ_TIMEOUT_EN only)
//
// Build option
//   SRIO_IREQ_TIMEOUT_EN  when defined, a DATA phase stalled for P_TIMEOUT
//                         cycles is completed with zero-filled beats.
module srio_ireq_gen #(
  parameter logic [7:0]  P_SRC_ID  = 8'h01,
  parameter logic [7:0]  P_DST_ID  = 8'h02,
  parameter logic [1:0]  P_PRIO    = 2'd1
`ifdef SRIO_IREQ_TIMEOUT_EN
  , parameter logic [15:0] P_TIMEOUT = 16'd1024
`endif
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_port_initialized,
  input  logic                    i_req_valid,
  output logic                    o_req_ready,
  input  logic [1:0]              i_req_type,
  input  logic [33:0]             i_req_addr,
  input  logic [8:0]              i_req_len,
  output logic                    o_req_err,
  input  logic                    s_data_tvalid,
  output logic                    s_data_tready,
  input  logic [63:0]             s_data_tdata,
  srio_ireq_gen_if.master         m_axis_ireq,
  output logic                    o_busy
`ifdef SRIO_IREQ_TIMEOUT_EN
  , output logic                  o_timeout
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA} state_e;
  typedef enum logic [1:0] {
    T_NWRITE   = 2'd0,
    T_NWRITE_R = 2'd1,
    T_SWRITE   = 2'd2,
    T_NREAD    = 2'd3
  } req_type_e;

  state_e      state;
  req_type_e   req_type_q;
  logic [33:0] req_addr_q;
  logic [7:0]  req_len_m1_q;
  logic [7:0]  tid;
  logic [4:0]  beat_cnt;
  logic [8:0]  len_m1;
  logic        len_bad;
  logic        cmd_fire;
  logic        m_fire;
  logic [3:0]  ftype;
  logic [3:0]  ttype;

`ifdef SRIO_IREQ_TIMEOUT_EN
  logic [15:0] stall_cnt;
  logic        pad_q;
`endif

  // len-1 wraps to 511 for len=0 and lands in 256..510 for len>256, so bit 8
  // alone flags every out-of-range length.
  assign len_m1   = i_req_len - 9'd1;
  assign len_bad  = len_m1[8] ||
                    ((i_req_type == T_SWRITE) && (i_req_len[2:0] != 3'd0));
  assign cmd_fire = i_req_valid && o_req_ready;
  assign m_fire   = m_axis_ireq.tvalid && m_axis_ireq.tready;

  assign o_req_ready       = (state == S_IDLE) && i_port_initialized;
  assign o_busy            = (state != S_IDLE);
  assign m_axis_ireq.tkeep = '1;
  assign m_axis_ireq.tuser = {8'h00, P_SRC_ID, 8'h00, P_DST_ID};

  always_comb begin
    ftype = 4'd5;
    ttype = 4'd4;
    unique case (req_type_q)
      T_NWRITE:   begin ftype = 4'd5; ttype = 4'd4; end
      T_NWRITE_R: begin ftype = 4'd5; ttype = 4'd5; end
      T_SWRITE:   begin ftype = 4'd6; ttype = 4'd0; end
      T_NREAD:    begin ftype = 4'd2; ttype = 4'd4; end
    endcase
  end

  always_comb begin
    m_axis_ireq.tvalid = 1'b0;
    m_axis_ireq.tlast  = 1'b0;
    m_axis_ireq.tdata  = '0;
    s_data_tready      = 1'b0;
    case (state)
      S_HDR: begin
        m_axis_ireq.tvalid = 1'b1;
        m_axis_ireq.tlast  = (req_type_q == T_NREAD);
        m_axis_ireq.tdata  = {tid, ftype, ttype, 1'b0, P_PRIO, 1'b0,
                              req_len_m1_q, 2'b00, req_addr_q};
      end
      S_DATA: begin
        // Last beat index is (len-1)>>3, i.e. ceil(len/8)-1.
        m_axis_ireq.tlast = (beat_cnt == req_len_m1_q[7:3]);
`ifdef SRIO_IREQ_TIMEOUT_EN
        if (pad_q) begin
          m_axis_ireq.tvalid = 1'b1;
        end else
`endif
        begin
          m_axis_ireq.tvalid = s_data_tvalid;
          m_axis_ireq.tdata  = s_data_tdata;
          s_data_tready      = m_axis_ireq.tready;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state        <= S_IDLE;
      tid          <= '0;
      beat_cnt     <= '0;
      req_type_q   <= T_NWRITE;
      req_addr_q   <= '0;
      req_len_m1_q <= '0;
      o_req_err    <= 1'b0;
    end else begin
      o_req_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_fire) begin
            if (len_bad) begin
              o_req_err <= 1'b1;
            end else begin
              req_type_q   <= req_type_e'(i_req_type);
              req_addr_q   <= i_req_addr;
              req_len_m1_q <= len_m1[7:0];
              state        <= S_HDR;
            end
          end
        end
        S_HDR: begin
          if (m_fire) begin
            tid      <= tid + 8'd1;
            beat_cnt <= '0;
            state    <= (req_type_q == T_NREAD) ? S_IDLE : S_DATA;
          end
        end
        S_DATA: begin
          if (m_fire) begin
            if (m_axis_ireq.tlast) begin
              beat_cnt <= '0;
              state    <= S_IDLE;
            end else begin
              beat_cnt <= beat_cnt + 5'd1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef SRIO_IREQ_TIMEOUT_EN
  always_ff @(posedge i_clk) begin
    if (!i_rst || (state != S_DATA)) begin
      stall_cnt <= '0;
      pad_q     <= 1'b0;
      o_timeout <= 1'b0;
    end else begin
      o_timeout <= 1'b0;
      if (s_data_tvalid) begin
        stall_cnt <= '0;
      end else if (!pad_q) begin
        stall_cnt <= stall_cnt + 16'd1;
        if ((stall_cnt + 16'd1) == P_TIMEOUT) begin
          pad_q     <= 1'b1;
          o_timeout <= 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_srio_ireq_gen.sv
module tb_srio_ireq_gen;

  typedef struct {
    logic [1:0]  typ;
    logic [33:0] addr;
    logic [8:0]  len;
    bit          tog;
    bit          gaps;
    bit          exp_err;
    logic [63:0] exp_hdr;
  } vec_t;

  typedef struct {
    logic [63:0] data;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        link = 1'b0;
  logic        req_valid = 1'b0;
  logic [1:0]  req_type = '0;
  logic [33:0] req_addr = '0;
  logic [8:0]  req_len = '0;
  logic        req_ready;
  logic        req_err;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [63:0] s_tdata = '0;
  logic        busy;

  srio_ireq_gen_if ireq ();

  srio_ireq_gen #(
    .P_SRC_ID (8'h01),
    .P_DST_ID (8'h02),
    .P_PRIO   (2'd1)
  ) dut (
    .i_clk              (clk),
    .i_rst              (rst_n),
    .i_port_initialized (link),
    .i_req_valid        (req_valid),
    .o_req_ready        (req_ready),
    .i_req_type         (req_type),
    .i_req_addr         (req_addr),
    .i_req_len          (req_len),
    .o_req_err          (req_err),
    .s_data_tvalid      (s_tvalid),
    .s_data_tready      (s_tready),
    .s_data_tdata       (s_tdata),
    .m_axis_ireq        (ireq),
    .o_busy             (busy)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  beat_t       sb[$];
  bit          tog_mode = 1'b0;
  vec_t        tab[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] hdr_model(input logic [7:0] tid, input logic [1:0] t,
                                            input logic [33:0] a, input logic [8:0] l);
    logic [3:0] ft;
    logic [3:0] tt;
    logic [8:0] lm;
    case (t)
      2'd0:    begin ft = 4'd5; tt = 4'd4; end
      2'd1:    begin ft = 4'd5; tt = 4'd5; end
      2'd2:    begin ft = 4'd6; tt = 4'd0; end
      default: begin ft = 4'd2; tt = 4'd4; end
    endcase
    lm = l - 9'd1;
    return {tid, ft, tt, 1'b0, 2'd1, 1'b0, lm[7:0], 2'b00, a};
  endfunction

  task automatic push_beat(input logic [63:0] d, input logic last);
    beat_t b;
    b.data = d;
    b.last = last;
    sb.push_back(b);
  endtask

  task automatic monitor();
    logic        pv = 1'b0;
    logic        pl = 1'b0;
    logic [63:0] pd = '0;
    beat_t       b;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv = 1'b0;
      end else begin
        if (pv) begin
          chk("stall_tvalid", ireq.tvalid, 1);
          chk("stall_tdata", ireq.tdata, pd);
          chk("stall_tlast", ireq.tlast, pl);
        end
        if (ireq.tvalid && ireq.tready) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_beat: got tdata %h, expected no beat", ireq.tdata);
          end else begin
            b = sb.pop_front();
            chk("tdata", ireq.tdata, b.data);
            chk("tlast", ireq.tlast, b.last);
            chk("tkeep", ireq.tkeep, 8'hFF);
            chk("tuser", ireq.tuser, 32'h0001_0002);
          end
        end
        pv = ireq.tvalid && !ireq.tready;
        pd = ireq.tdata;
        pl = ireq.tlast;
      end
    end
  endtask

  task automatic tready_drv();
    forever begin
      @(posedge clk);
      #1;
      ireq.tready = tog_mode ? ~ireq.tready : 1'b1;
    end
  endtask

  task automatic send_cmd(input logic [1:0] t, input logic [33:0] a, input logic [8:0] l);
    bit ok;
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_type  = t;
    req_addr  = a;
    req_len   = l;
    ok = 1'b0;
    for (int unsigned i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      if (req_ready) ok = 1'b1;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL cmd_accept: got no o_req_ready, expected command handshake");
    end
  endtask

  task automatic send_data(input logic [63:0] d[$], input bit gaps);
    bit ok;
    for (int unsigned i = 0; i < d.size(); i++) begin
      if (gaps) begin
        s_tvalid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
      end
      s_tvalid = 1'b1;
      s_tdata  = d[i];
      ok = 1'b0;
      for (int unsigned k = 0; k < 64 && !ok; k++) begin
        @(negedge clk);
        if (s_tready) ok = 1'b1;
      end
      @(posedge clk);
      #1;
      if (!ok) begin
        n_cmp++;
        n_err++;
        $display("FAIL data_accept: got no s_data_tready on beat %0d, expected handshake", i);
      end
    end
    s_tvalid = 1'b0;
  endtask

  task automatic wait_done();
    bit done = 1'b0;
    for (int unsigned i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy) done = 1'b1;
    end
    chk("packet_drained", {63'd0, done}, 64'd1);
  endtask

  initial begin
    logic [63:0] d[$];
    logic [63:0] dat;
    int unsigned nb;
    bit          b;

    ireq.tready = 1'b1;
    fork
      monitor();
      tready_drv();
    join_none

    // {type, addr, len, tready toggling, data gaps, expect reject, expected header}
    tab[0] = '{2'd0, 34'h0_0000_1000, 9'd16,  1'b0, 1'b0, 1'b0, 64'h0054_20F0_0000_1000};
    tab[1] = '{2'd3, 34'h3_FFFF_FF00, 9'd256, 1'b0, 1'b0, 1'b0, 64'h0124_2FF3_FFFF_FF00};
    tab[2] = '{2'd2, 34'h0_0000_3000, 9'd12,  1'b0, 1'b0, 1'b1, 64'd0};
    tab[3] = '{2'd0, 34'h0_0000_3000, 9'd0,   1'b0, 1'b0, 1'b1, 64'd0};
    tab[4] = '{2'd0, 34'h0_0000_3000, 9'd257, 1'b0, 1'b0, 1'b1, 64'd0};
    tab[5] = '{2'd1, 34'h0_0000_2000, 9'd9,   1'b1, 1'b1, 1'b0, 64'h0255_2080_0000_2000};
    tab[6] = '{2'd2, 34'h1_2345_6780, 9'd32,  1'b1, 1'b0, 1'b0, 64'h0360_21F1_2345_6780};
    tab[7] = '{2'd0, 34'h0_0000_0008, 9'd1,   1'b0, 1'b0, 1'b0, 64'h0454_2000_0000_0008};
    tab[8] = '{2'd3, 34'h0_0000_0000, 9'd8,   1'b1, 1'b0, 1'b0, 64'h0524_2070_0000_0000};
    tab[9] = '{2'd0, 34'h0_8000_0000, 9'd256, 1'b0, 1'b1, 1'b0, 64'h0654_2FF0_8000_0000};

    // Reset state, link down.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", ireq.tvalid, 0);
    chk("rst_tlast", ireq.tlast, 0);
    chk("rst_tdata", ireq.tdata, 0);
    chk("rst_tkeep", ireq.tkeep, 8'hFF);
    chk("rst_s_tready", s_tready, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_req_err", req_err, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    link  = 1'b1;

    for (int unsigned v = 0; v < 10; v++) begin
      d = {};
      tog_mode = tab[v].tog;
      if (!tab[v].exp_err) begin
        push_beat(tab[v].exp_hdr, tab[v].typ == 2'd3);
        if (tab[v].typ != 2'd3) begin
          nb = (int'(tab[v].len) + 7) / 8;
          for (int unsigned i = 0; i < nb; i++) begin
            if (v == 0) dat = (i == 0) ? 64'hAAAA_AAAA_AAAA_AAAA : 64'hBBBB_BBBB_BBBB_BBBB;
            else        dat = {$urandom(), $urandom()};
            push_beat(dat, i == nb - 1);
            d.push_back(dat);
          end
        end
      end
      send_cmd(tab[v].typ, tab[v].addr, tab[v].len);
      if (tab[v].exp_err) begin
        @(negedge clk);
        chk("req_err_pulse", req_err, 1);
        chk("reject_busy", busy, 0);
        @(negedge clk);
        chk("req_err_clear", req_err, 0);
        repeat (3) @(negedge clk);
      end else if (tab[v].typ == 2'd3) begin
        b = 1'b1;
        for (int unsigned i = 0; i < 16 && b; i++) begin
          @(negedge clk);
          chk("nread_s_tready", s_tready, 0);
          b = busy;
        end
        wait_done();
      end else begin
        send_data(d, tab[v].gaps);
        wait_done();
      end
    end
    tog_mode = 1'b0;

    // Reset after 1 of 4 data beats; next command restarts at TID 0.
    push_beat(hdr_model(8'd7, 2'd0, 34'h0_0000_0040, 9'd32), 1'b0);
    push_beat(64'h1111_2222_3333_4444, 1'b0);
    send_cmd(2'd0, 34'h0_0000_0040, 9'd32);
    d = {64'h1111_2222_3333_4444};
    send_data(d, 1'b0);
    s_tvalid = 1'b1;
    s_tdata  = 64'h5555_6666_7777_8888;
    rst_n    = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("midrst_tvalid", ireq.tvalid, 0);
    chk("midrst_tlast", ireq.tlast, 0);
    chk("midrst_tdata", ireq.tdata, 0);
    chk("midrst_s_tready", s_tready, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_sb_empty", sb.size(), 0);
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    s_tvalid = 1'b0;
    push_beat(64'h0024_2070_0000_0100, 1'b1);
    send_cmd(2'd3, 34'h0_0000_0100, 9'd8);
    wait_done();

    // Link drop mid-packet: packet still completes, then no acceptance.
    push_beat(hdr_model(8'd1, 2'd0, 34'h0_0000_0080, 9'd16), 1'b0);
    push_beat(64'hCAFE_0000_0000_0001, 1'b0);
    push_beat(64'hCAFE_0000_0000_0002, 1'b1);
    send_cmd(2'd0, 34'h0_0000_0080, 9'd16);
    link = 1'b0;
    d = {64'hCAFE_0000_0000_0001, 64'hCAFE_0000_0000_0002};
    send_data(d, 1'b0);
    wait_done();
    req_valid = 1'b1;
    req_type  = 2'd3;
    req_len   = 9'd8;
    for (int unsigned i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("linkdown_ready", req_ready, 0);
      chk("linkdown_busy", busy, 0);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    link      = 1'b1;

    // 257 NREADs from reset: TID 0..255 then wraps to 0.
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int unsigned i = 0; i < 257; i++) begin
      push_beat(hdr_model(i[7:0], 2'd3, 34'(i * 8), 9'd8), 1'b1);
      send_cmd(2'd3, 34'(i * 8), 9'd8);
      wait_done();
    end

    chk("final_sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
